// File: rtl/cva6_ras_ckpt.sv
// rtl/cva6_ras_ckpt.sv - return-address stack with in-order checkpoint/restore queue
// Optional feature macro: CVA6_RAS_STATS_EN (overflow/underflow event counters).
module cva6_ras_ckpt #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned VLEN    = 32,
  parameter int unsigned NR_CKPT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            addr_i,
  output logic [VLEN-1:0]            data_o,
  output logic                       valid_o,
  input  logic                       ckpt_save_i,
  output logic [$clog2(NR_CKPT)-1:0] ckpt_id_o,
  output logic                       ckpt_full_o,
  input  logic                       ckpt_restore_i,
  input  logic [$clog2(NR_CKPT)-1:0] ckpt_restore_id_i,
  input  logic                       ckpt_release_i,
  output logic [15:0]                overflow_cnt_o,
  output logic [15:0]                underflow_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(NR_CKPT);

  logic [VLEN-1:0] entry_q    [DEPTH];
  logic [PW-1:0]   tos_q;
  logic [NW-1:0]   cnt_q;
  logic [PW-1:0]   slot_tos_q [NR_CKPT];
  logic [NW-1:0]   slot_cnt_q [NR_CKPT];
  logic [VLEN-1:0] slot_top_q [NR_CKPT];
  logic [CW-1:0]   head_q;
  logic [CW-1:0]   tail_q;
  logic            full_q;

  logic [CW:0]     live;
  logic [CW-1:0]   restore_off;
  logic            restore_ok;
  logic            release_ok;
  logic            save_ok;
  logic            head_hit;
  logic            do_push;
  logic            do_pop;
  logic            do_both;
  logic            stack_full;
  logic            stack_empty;
  logic [PW-1:0]   tos_n;
  logic [NW-1:0]   cnt_n;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [VLEN-1:0] wr_data;
  logic [VLEN-1:0] top_n;

  always_comb begin
    // head == tail is ambiguous, so the full flag disambiguates live count
    live        = full_q ? (CW+1)'(NR_CKPT) : {1'b0, tail_q - head_q};
    restore_off = ckpt_restore_id_i - head_q;
    restore_ok  = ckpt_restore_i && ({1'b0, restore_off} < live);
    head_hit    = (restore_off == '0);
    release_ok  = ckpt_release_i && (live != '0);
    save_ok     = ckpt_save_i && !full_q && !restore_ok;
    do_push     = push_i && !pop_i && !restore_ok;
    do_pop      = pop_i && !push_i && !restore_ok;
    do_both     = push_i && pop_i && !restore_ok;
    stack_full  = (cnt_q == NW'(DEPTH));
    stack_empty = (cnt_q == '0);

    tos_n   = tos_q;
    cnt_n   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = addr_i;
    if (restore_ok) begin
      tos_n   = slot_tos_q[ckpt_restore_id_i];
      cnt_n   = slot_cnt_q[ckpt_restore_id_i];
      wr_en   = 1'b1;
      wr_idx  = slot_tos_q[ckpt_restore_id_i];
      wr_data = slot_top_q[ckpt_restore_id_i];
    end else if (do_push) begin
      tos_n  = tos_q + PW'(1);
      cnt_n  = stack_full ? cnt_q : cnt_q + NW'(1);
      wr_en  = 1'b1;
      wr_idx = tos_n;
    end else if (do_pop && !stack_empty) begin
      tos_n = tos_q - PW'(1);
      cnt_n = cnt_q - NW'(1);
    end else if (do_both) begin
      wr_en = 1'b1;
      if (stack_empty) cnt_n = NW'(1);
    end
    // top value as it will be after this edge, captured by a save
    top_n = (wr_en && (wr_idx == tos_n)) ? wr_data : entry_q[tos_n];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      for (int i = 0; i < NR_CKPT; i++) begin
        slot_tos_q[i] <= '0;
        slot_cnt_q[i] <= '0;
        slot_top_q[i] <= '0;
      end
      tos_q  <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      full_q <= 1'b0;
    end else begin
      tos_q <= tos_n;
      cnt_q <= cnt_n;
      if (wr_en) entry_q[wr_idx] <= wr_data;
      if (save_ok) begin
        slot_tos_q[tail_q] <= tos_n;
        slot_cnt_q[tail_q] <= cnt_n;
        slot_top_q[tail_q] <= top_n;
        tail_q             <= tail_q + CW'(1);
      end
      if (restore_ok) tail_q <= ckpt_restore_id_i;
      // restoring the oldest slot frees everything, so the release has nothing to pop
      if (release_ok && !(restore_ok && head_hit)) head_q <= head_q + CW'(1);
      full_q <= !restore_ok &&
                ((full_q && !release_ok) ||
                 (save_ok && !release_ok && ((tail_q + CW'(1)) == head_q)));
    end
  end

  assign data_o      = entry_q[tos_q];
  assign valid_o     = (cnt_q != '0);
  assign ckpt_id_o   = tail_q;
  assign ckpt_full_o = full_q;

`ifdef CVA6_RAS_STATS_EN
  logic [15:0] ovf_q;
  logic [15:0] unf_q;
  logic        ovf_ev;
  logic        unf_ev;

  assign ovf_ev = do_push && stack_full;
  assign unf_ev = do_pop && stack_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      if (ovf_ev && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      if (unf_ev && (unf_q != 16'hFFFF)) unf_q <= unf_q + 16'd1;
    end
  end

  assign overflow_cnt_o  = ovf_q;
  assign underflow_cnt_o = unf_q;
`else
  assign overflow_cnt_o  = '0;
  assign underflow_cnt_o = '0;
`endif

endmodule
